// File: rtl/sink_age_arbiter.sv
// Age-ordered N-channel request arbiter: forwards sink requests to one memory
// port through a registered stage and routes tagged responses back by channel.
module sink_age_arbiter #(
  parameter int NCH      = 9,
  parameter int IDBITS   = 4,
  parameter int ADDRBITS = 32,
  parameter int DATABITS = 512,
  parameter int MAXOUT   = 4,
  localparam int CHBITS  = $clog2(NCH),
  localparam int TAGW    = CHBITS + IDBITS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NCH-1:0]           s_req_valid,
  output logic [NCH-1:0]           s_req_ready,
  input  logic [NCH*IDBITS-1:0]    s_req_id,
  input  logic [NCH*ADDRBITS-1:0]  s_req_addr,
  input  logic [NCH*DATABITS-1:0]  s_req_data,
  input  logic [NCH-1:0]           s_req_rw,
  output logic [NCH-1:0]           s_rsp_valid,
  input  logic [NCH-1:0]           s_rsp_ready,
  output logic [IDBITS-1:0]        s_rsp_id,
  output logic [DATABITS-1:0]      s_rsp_data,
  output logic [1:0]               s_rsp_resp,
  output logic                     s_rsp_rw,
  output logic                     m_req_valid,
  input  logic                     m_req_ready,
  output logic [TAGW-1:0]          m_req_tag,
  output logic [ADDRBITS-1:0]      m_req_addr,
  output logic [DATABITS-1:0]      m_req_data,
  output logic                     m_req_rw,
  input  logic                     m_rsp_valid,
  output logic                     m_rsp_ready,
  input  logic [TAGW-1:0]          m_rsp_tag,
  input  logic [DATABITS-1:0]      m_rsp_data,
  input  logic [1:0]               m_rsp_resp,
  input  logic                     m_rsp_rw,
  output logic                     err_badtag
);

  localparam logic [4:0]      MaxOutW = 5'(MAXOUT);
  localparam logic [CHBITS:0] NchW    = (CHBITS+1)'(NCH);

  logic [NCH-1:0]          r_pend;
  logic [NCH-1:0]          r_busy;
  logic [NCH-1:0][NCH-1:0] r_older;
  logic [NCH-1:0][NCH-1:0] w_older;
  logic [NCH-1:0]          w_elig;
  logic [NCH-1:0]          w_oldest;
  logic [NCH-1:0]          w_grant;
  logic [NCH-1:0]          w_rspDone;

  logic                    r_reqValid;
  logic [TAGW-1:0]         r_reqTag;
  logic [ADDRBITS-1:0]     r_reqAddr;
  logic [DATABITS-1:0]     r_reqData;
  logic                    r_reqRw;

  logic                    r_rspValid;
  logic [TAGW-1:0]         r_rspTag;
  logic [DATABITS-1:0]     r_rspData;
  logic [1:0]              r_rspResp;
  logic                    r_rspRw;

  logic [3:0]              r_inflight;
  logic [4:0]              w_inflightNext;
  logic [1:0]              w_dec;
  logic                    r_errBadTag;

  logic                    w_mReqXfer;
  logic                    w_sRspXfer;
  logic                    w_mRspXfer;
  logic                    w_canGrant;
  logic                    w_anyGrant;
  logic                    w_badTag;
  logic [CHBITS-1:0]       w_rspCh;
  logic [CHBITS-1:0]       w_inCh;

  logic [TAGW-1:0]         w_selTag;
  logic [ADDRBITS-1:0]     w_selAddr;
  logic [DATABITS-1:0]     w_selData;
  logic                    w_selRw;

  // Resolved age order for this cycle: already-pending channels keep their
  // stored order, newcomers are younger, and simultaneous newcomers go by index.
  always_comb begin
    w_older = '0;
    for (int i = 0; i < NCH; i++) begin
      for (int j = 0; j < NCH; j++) begin
        if (r_pend[i] && r_pend[j]) w_older[i][j] = r_older[i][j];
        else if (r_pend[i])         w_older[i][j] = 1'b1;
        else if (r_pend[j])         w_older[i][j] = 1'b0;
        else                        w_older[i][j] = (i < j);
      end
    end
  end

  assign w_elig = s_req_valid & ~r_busy;

  always_comb begin
    w_oldest = w_elig;
    for (int i = 0; i < NCH; i++) begin
      for (int j = 0; j < NCH; j++) begin
        if (i != j && w_elig[j] && !w_older[i][j]) w_oldest[i] = 1'b0;
      end
    end
  end

  assign w_mReqXfer  = r_reqValid & m_req_ready;
  assign w_canGrant  = ~reset & (~r_reqValid | w_mReqXfer) &
                       (({1'b0, r_inflight} + {4'b0, r_reqValid}) < MaxOutW);
  assign w_grant     = w_canGrant ? w_oldest : '0;
  assign w_anyGrant  = |w_grant;
  assign s_req_ready = w_grant;

  always_comb begin
    w_selTag  = '0;
    w_selAddr = '0;
    w_selData = '0;
    w_selRw   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (w_grant[i]) begin
        w_selTag  = {CHBITS'(i), s_req_id[i*IDBITS +: IDBITS]};
        w_selAddr = s_req_addr[i*ADDRBITS +: ADDRBITS];
        w_selData = s_req_data[i*DATABITS +: DATABITS];
        w_selRw   = s_req_rw[i];
      end
    end
  end

  assign w_rspCh = r_rspTag[TAGW-1:IDBITS];

  always_comb begin
    s_rsp_valid = '0;
    for (int i = 0; i < NCH; i++) begin
      s_rsp_valid[i] = r_rspValid && (w_rspCh == CHBITS'(i));
    end
  end

  assign w_rspDone   = s_rsp_valid & s_rsp_ready;
  assign w_sRspXfer  = |w_rspDone;
  assign m_rsp_ready = ~reset & (~r_rspValid | w_sRspXfer);
  assign w_mRspXfer  = m_rsp_valid & m_rsp_ready;
  assign w_inCh      = m_rsp_tag[TAGW-1:IDBITS];
  assign w_badTag    = {1'b0, w_inCh} >= NchW;

  // A delivered response and a dropped bad tag can retire in the same cycle.
  assign w_dec = {1'b0, w_sRspXfer} + {1'b0, w_mRspXfer & w_badTag};

  always_comb begin
    w_inflightNext = {1'b0, r_inflight} + {4'b0, w_mReqXfer};
    if (w_inflightNext >= {3'b0, w_dec}) w_inflightNext = w_inflightNext - {3'b0, w_dec};
    else                                 w_inflightNext = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend      <= '0;
      r_busy      <= '0;
      r_older     <= '0;
      r_inflight  <= '0;
      r_errBadTag <= 1'b0;
    end else begin
      r_pend     <= s_req_valid & ~w_grant;
      r_busy     <= (r_busy & ~w_rspDone) | w_grant;
      r_older    <= w_older;
      r_inflight <= w_inflightNext[3:0];
      if (w_mRspXfer && w_badTag) r_errBadTag <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_reqValid <= 1'b0;
      r_reqTag   <= '0;
      r_reqAddr  <= '0;
      r_reqData  <= '0;
      r_reqRw    <= 1'b0;
    end else if (w_anyGrant) begin
      r_reqValid <= 1'b1;
      r_reqTag   <= w_selTag;
      r_reqAddr  <= w_selAddr;
      r_reqData  <= w_selData;
      r_reqRw    <= w_selRw;
    end else if (w_mReqXfer) begin
      r_reqValid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rspValid <= 1'b0;
      r_rspTag   <= '0;
      r_rspData  <= '0;
      r_rspResp  <= '0;
      r_rspRw    <= 1'b0;
    end else if (w_mRspXfer && !w_badTag) begin
      r_rspValid <= 1'b1;
      r_rspTag   <= m_rsp_tag;
      r_rspData  <= m_rsp_data;
      r_rspResp  <= m_rsp_resp;
      r_rspRw    <= m_rsp_rw;
    end else if (w_sRspXfer) begin
      r_rspValid <= 1'b0;
    end
  end

  assign m_req_valid = r_reqValid;
  assign m_req_tag   = r_reqTag;
  assign m_req_addr  = r_reqAddr;
  assign m_req_data  = r_reqData;
  assign m_req_rw    = r_reqRw;
  assign s_rsp_id    = r_rspTag[IDBITS-1:0];
  assign s_rsp_data  = r_rspData;
  assign s_rsp_resp  = r_rspResp;
  assign s_rsp_rw    = r_rspRw;
  assign err_badtag  = r_errBadTag;

endmodule

// File: tb/tb_sink_age_arbiter.sv
// Scoreboard bench for sink_age_arbiter: expected requests queued at stimulus
// time, expected responses queued when the memory model answers.
module tb_sink_age_arbiter;

  localparam int NCH      = 9;
  localparam int IDBITS   = 4;
  localparam int ADDRBITS = 32;
  localparam int DATABITS = 512;
  localparam int MAXOUT   = 4;
  localparam int TAGW     = 8;

  typedef struct {
    logic [TAGW-1:0]     tag;
    logic [ADDRBITS-1:0] addr;
    logic [DATABITS-1:0] data;
    logic                rw;
  } req_t;

  typedef struct {
    int                  ch;
    logic [IDBITS-1:0]   id;
    logic [DATABITS-1:0] data;
    logic [1:0]          resp;
    logic                rw;
  } rsp_t;

  typedef struct {
    logic [TAGW-1:0]     tag;
    logic [DATABITS-1:0] data;
    logic [1:0]          resp;
    logic                rw;
  } mem_t;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [NCH-1:0]          s_req_valid;
  logic [NCH-1:0]          s_req_ready;
  logic [NCH*IDBITS-1:0]   s_req_id;
  logic [NCH*ADDRBITS-1:0] s_req_addr;
  logic [NCH*DATABITS-1:0] s_req_data;
  logic [NCH-1:0]          s_req_rw;
  logic [NCH-1:0]          s_rsp_valid;
  logic [NCH-1:0]          s_rsp_ready;
  logic [IDBITS-1:0]       s_rsp_id;
  logic [DATABITS-1:0]     s_rsp_data;
  logic [1:0]              s_rsp_resp;
  logic                    s_rsp_rw;
  logic                    m_req_valid;
  logic                    m_req_ready;
  logic [TAGW-1:0]         m_req_tag;
  logic [ADDRBITS-1:0]     m_req_addr;
  logic [DATABITS-1:0]     m_req_data;
  logic                    m_req_rw;
  logic                    m_rsp_valid;
  logic                    m_rsp_ready;
  logic [TAGW-1:0]         m_rsp_tag;
  logic [DATABITS-1:0]     m_rsp_data;
  logic [1:0]              m_rsp_resp;
  logic                    m_rsp_rw;
  logic                    err_badtag;

  req_t expReqQ[$];
  req_t memQ[$];
  rsp_t expRspQ[$];
  mem_t manualQ[$];
  int   mCycles[$];
  int   checks, failures, cyc, mCount, sCount, rspCredits;

  sink_age_arbiter #(
    .NCH(NCH), .IDBITS(IDBITS), .ADDRBITS(ADDRBITS), .DATABITS(DATABITS), .MAXOUT(MAXOUT)
  ) dut (
    .clock(clock), .reset(reset),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_id(s_req_id),
    .s_req_addr(s_req_addr), .s_req_data(s_req_data), .s_req_rw(s_req_rw),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_id(s_rsp_id),
    .s_rsp_data(s_rsp_data), .s_rsp_resp(s_rsp_resp), .s_rsp_rw(s_rsp_rw),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_tag(m_req_tag),
    .m_req_addr(m_req_addr), .m_req_data(m_req_data), .m_req_rw(m_req_rw),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_tag(m_rsp_tag),
    .m_rsp_data(m_rsp_data), .m_rsp_resp(m_rsp_resp), .m_rsp_rw(m_rsp_rw),
    .err_badtag(err_badtag)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [ADDRBITS-1:0] mkAddr(input int ch, input logic [IDBITS-1:0] id);
    return 32'h4000_0000 + 32'(ch) * 32'h100 + 32'(id);
  endfunction

  function automatic logic [DATABITS-1:0] mkData(input int ch, input logic [IDBITS-1:0] id);
    logic [DATABITS-1:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = {8'(ch), id, 4'h0, 16'(k) ^ 16'hBEEF};
    return d;
  endfunction

  function automatic logic [DATABITS-1:0] rspData(input logic [TAGW-1:0] tag);
    return {16{~tag, tag, 16'h600D}};
  endfunction

  // Raising a request is the stimulus event: the expected downstream order
  // equals raise order, with same-cycle raises issued in index order.
  task automatic raiseReq(input int ch, input logic [IDBITS-1:0] id, input logic rw);
    req_t e;
    s_req_id[ch*IDBITS +: IDBITS]       = id;
    s_req_addr[ch*ADDRBITS +: ADDRBITS] = mkAddr(ch, id);
    s_req_data[ch*DATABITS +: DATABITS] = mkData(ch, id);
    s_req_rw[ch]                        = rw;
    s_req_valid[ch]                     = 1'b1;
    e.tag  = {4'(ch), id};
    e.addr = mkAddr(ch, id);
    e.data = mkData(ch, id);
    e.rw   = rw;
    expReqQ.push_back(e);
  endtask

  // One clock: sample handshakes on the falling edge, then update the
  // senders and the memory model just after the rising edge.
  task automatic cycle();
    logic [NCH-1:0] acc;
    logic           mRspX;
    req_t           e;
    rsp_t           r;
    mem_t           m;
    @(negedge clock);
    acc = s_req_valid & s_req_ready;
    checks++;
    if ((s_req_ready & ~s_req_valid) != 0 || $countones(s_req_ready) > 1) begin
      failures++;
      $display("[TB] FAIL grant_shape: ready=%b valid=%b", s_req_ready, s_req_valid);
    end
    if (m_req_valid && m_req_ready) begin
      mCount++;
      mCycles.push_back(cyc);
      checks++;
      if (expReqQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL m_req_unexpected: got tag=%h expected none", m_req_tag);
      end else begin
        e = expReqQ.pop_front();
        if (m_req_tag !== e.tag || m_req_addr !== e.addr || m_req_data !== e.data || m_req_rw !== e.rw) begin
          failures++;
          $display("[TB] FAIL m_req_order: got tag=%h addr=%h rw=%b expected tag=%h addr=%h rw=%b",
                   m_req_tag, m_req_addr, m_req_rw, e.tag, e.addr, e.rw);
        end
        memQ.push_back(e);
      end
    end
    mRspX = m_rsp_valid && m_rsp_ready;
    if (mRspX && int'(m_rsp_tag[7:4]) < NCH) begin
      r.ch   = int'(m_rsp_tag[7:4]);
      r.id   = m_rsp_tag[3:0];
      r.data = m_rsp_data;
      r.resp = m_rsp_resp;
      r.rw   = m_rsp_rw;
      expRspQ.push_back(r);
    end
    if (|(s_rsp_valid & s_rsp_ready)) begin
      sCount++;
      checks++;
      if (expRspQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL s_rsp_unexpected: got valid=%b id=%h expected none", s_rsp_valid, s_rsp_id);
      end else begin
        r = expRspQ.pop_front();
        if (s_rsp_valid !== (NCH'(1) << r.ch) || s_rsp_id !== r.id || s_rsp_data !== r.data ||
            s_rsp_resp !== r.resp || s_rsp_rw !== r.rw) begin
          failures++;
          $display("[TB] FAIL s_rsp_route: got valid=%b id=%h resp=%b rw=%b expected valid=%b id=%h resp=%b rw=%b",
                   s_rsp_valid, s_rsp_id, s_rsp_resp, s_rsp_rw, NCH'(1) << r.ch, r.id, r.resp, r.rw);
        end
      end
    end
    @(posedge clock);
    #1;
    s_req_valid = s_req_valid & ~acc;
    if (mRspX) m_rsp_valid = 1'b0;
    if (!m_rsp_valid) begin
      if (manualQ.size() > 0) begin
        m = manualQ.pop_front();
        m_rsp_tag = m.tag; m_rsp_data = m.data; m_rsp_resp = m.resp; m_rsp_rw = m.rw;
        m_rsp_valid = 1'b1;
      end else if (rspCredits > 0 && memQ.size() > 0) begin
        e = memQ.pop_front();
        m_rsp_tag = e.tag; m_rsp_data = rspData(e.tag); m_rsp_resp = e.tag[1:0]; m_rsp_rw = e.rw;
        m_rsp_valid = 1'b1;
        rspCredits--;
      end
    end
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((expReqQ.size() != 0 || memQ.size() != 0 || expRspQ.size() != 0 || manualQ.size() != 0 ||
            m_rsp_valid || s_req_valid != 0) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (expReqQ.size() != 0 || memQ.size() != 0 || expRspQ.size() != 0 || s_req_valid != 0) begin
      failures++;
      $display("[TB] FAIL drain_timeout: got req=%0d mem=%0d rsp=%0d left expected 0",
               expReqQ.size(), memQ.size(), expRspQ.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s_req_valid = '1;
    m_rsp_valid = 1'b1;
    m_rsp_tag   = 8'h10;
    #3;
    checks += 5;
    if (s_req_ready !== '0) begin failures++; $display("[TB] FAIL reset_s_req_ready: got %b expected 0", s_req_ready); end
    if (m_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_req_valid: got %b expected 0", m_req_valid); end
    if (m_rsp_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_rsp_ready: got %b expected 0", m_rsp_ready); end
    if (s_rsp_valid !== '0) begin failures++; $display("[TB] FAIL reset_s_rsp_valid: got %b expected 0", s_rsp_valid); end
    if (err_badtag !== 1'b0) begin failures++; $display("[TB] FAIL reset_err_badtag: got %b expected 0", err_badtag); end
    s_req_valid = '0;
    m_rsp_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (m_rsp_ready !== 1'b1) begin failures++; $display("[TB] FAIL idle_m_rsp_ready: got %b expected 1", m_rsp_ready); end
  endtask

  task automatic test_simultaneous();
    mCycles.delete();
    rspCredits  = 1000;
    m_req_ready = 1'b1;
    s_rsp_ready = '1;
    for (int ch = 0; ch < NCH; ch++) raiseReq(ch, 4'(ch + 1), 1'(ch % 2));
    cyc = 0;
    drain(100);
    checks++;
    if (mCycles.size() != NCH) begin
      failures++;
      $display("[TB] FAIL sim_count: got %0d transfers expected %0d", mCycles.size(), NCH);
    end
    for (int k = 0; k < mCycles.size() && k < NCH; k++) begin
      checks++;
      if (mCycles[k] != k + 1) begin
        failures++;
        $display("[TB] FAIL sim_timing: transfer %0d got cycle %0d expected %0d", k, mCycles[k], k + 1);
      end
    end
  endtask

  task automatic test_staggered();
    int ord[NCH] = '{0, 2, 4, 6, 8, 1, 3, 5, 7};
    int base;
    base = mCount;
    rspCredits  = 1000;
    m_req_ready = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      raiseReq(ord[k], 4'(ord[k] + 7), 1'b1);
      cycle();
    end
    repeat (11) cycle();
    m_req_ready = 1'b1;
    drain(200);
    checks++;
    if (mCount - base != NCH) begin
      failures++;
      $display("[TB] FAIL stagger_count: got %0d expected %0d", mCount - base, NCH);
    end
  endtask

  task automatic test_inflight_limit();
    int base;
    base = mCount;
    rspCredits  = 0;
    m_req_ready = 1'b1;
    for (int ch = 0; ch < 6; ch++) raiseReq(ch, 4'(ch + 2), 1'b0);
    repeat (12) cycle();
    #1;
    checks += 2;
    if (mCount - base != MAXOUT) begin failures++; $display("[TB] FAIL limit_count: got %0d expected %0d", mCount - base, MAXOUT); end
    if (s_req_ready !== '0) begin failures++; $display("[TB] FAIL limit_ready: got %b expected 0", s_req_ready); end
    rspCredits = 1;
    repeat (12) cycle();
    #1;
    checks += 2;
    if (mCount - base != MAXOUT + 1) begin failures++; $display("[TB] FAIL limit_release: got %0d expected %0d", mCount - base, MAXOUT + 1); end
    if (s_req_ready !== '0) begin failures++; $display("[TB] FAIL limit_ready2: got %b expected 0", s_req_ready); end
    rspCredits = 1000;
    drain(100);
  endtask

  task automatic test_rsp_routing();
    int   chs[3] = '{3, 0, 7};
    logic [IDBITS-1:0] ids[3] = '{4'h5, 4'hA, 4'hC};
    logic rws[3] = '{1'b0, 1'b1, 1'b1};
    int   base, sBase;
    mem_t m;
    base  = mCount;
    sBase = sCount;
    rspCredits  = 0;
    m_req_ready = 1'b1;
    raiseReq(0, 4'hA, 1'b1);
    raiseReq(3, 4'h5, 1'b0);
    raiseReq(7, 4'hC, 1'b1);
    repeat (6) cycle();
    checks++;
    if (mCount - base != 3) begin failures++; $display("[TB] FAIL route_issue: got %0d expected 3", mCount - base); end
    memQ.delete();
    for (int k = 0; k < 3; k++) begin
      m.tag  = {4'(chs[k]), ids[k]};
      m.data = DATABITS'(chs[k]) << 30;
      m.resp = 2'(k + 1);
      m.rw   = rws[k];
      manualQ.push_back(m);
    end
    drain(50);
    checks++;
    if (sCount - sBase != 3) begin failures++; $display("[TB] FAIL route_count: got %0d expected 3", sCount - sBase); end
  endtask

  task automatic test_backpressure_badtag();
    int   base, sBase;
    mem_t m;
    rspCredits  = 1000;
    m_req_ready = 1'b1;
    s_rsp_ready = ~(NCH'(1) << 2);
    raiseReq(2, 4'h6, 1'b1);
    raiseReq(4, 4'h9, 1'b0);
    repeat (10) cycle();
    checks += 3;
    if (m_rsp_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_m_rsp_ready: got %b expected 0", m_rsp_ready); end
    if (m_rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_second_rsp: got %b expected 1", m_rsp_valid); end
    if (s_rsp_valid !== (NCH'(1) << 2)) begin failures++; $display("[TB] FAIL bp_s_rsp_valid: got %b expected %b", s_rsp_valid, NCH'(1) << 2); end
    s_rsp_ready = '1;
    drain(50);

    base  = mCount;
    sBase = sCount;
    rspCredits = 0;
    for (int ch = 0; ch < 5; ch++) raiseReq(ch, 4'(ch + 3), 1'b1);
    repeat (8) cycle();
    checks += 2;
    if (mCount - base != MAXOUT) begin failures++; $display("[TB] FAIL bad_pre_count: got %0d expected %0d", mCount - base, MAXOUT); end
    if (err_badtag !== 1'b0) begin failures++; $display("[TB] FAIL bad_pre_err: got %b expected 0", err_badtag); end
    m.tag  = {4'hF, 4'h3};
    m.data = '1;
    m.resp = 2'b11;
    m.rw   = 1'b1;
    manualQ.push_back(m);
    repeat (6) cycle();
    checks += 3;
    if (err_badtag !== 1'b1) begin failures++; $display("[TB] FAIL bad_err: got %b expected 1", err_badtag); end
    if (mCount - base != MAXOUT + 1) begin failures++; $display("[TB] FAIL bad_freed: got %0d expected %0d", mCount - base, MAXOUT + 1); end
    if (sCount != sBase) begin failures++; $display("[TB] FAIL bad_delivered: got %0d expected %0d", sCount, sBase); end
    rspCredits = 1000;
    drain(100);
    checks++;
    if (err_badtag !== 1'b1) begin failures++; $display("[TB] FAIL bad_sticky: got %b expected 1", err_badtag); end
  endtask

  task automatic test_reset_midburst();
    rspCredits  = 1000;
    m_req_ready = 1'b1;
    for (int ch = 0; ch < NCH; ch++) raiseReq(ch, 4'(ch + 1), 1'(ch % 2));
    repeat (3) cycle();
    #2 reset = 1'b1;
    #1;
    checks += 5;
    if (s_req_ready !== '0) begin failures++; $display("[TB] FAIL mid_s_req_ready: got %b expected 0", s_req_ready); end
    if (m_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_m_req_valid: got %b expected 0", m_req_valid); end
    if (m_rsp_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_m_rsp_ready: got %b expected 0", m_rsp_ready); end
    if (s_rsp_valid !== '0) begin failures++; $display("[TB] FAIL mid_s_rsp_valid: got %b expected 0", s_rsp_valid); end
    if (err_badtag !== 1'b0) begin failures++; $display("[TB] FAIL mid_err_badtag: got %b expected 0", err_badtag); end
    expReqQ.delete();
    memQ.delete();
    expRspQ.delete();
    manualQ.delete();
    s_req_valid = '0;
    m_rsp_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    test_simultaneous();
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; mCount = 0; sCount = 0; rspCredits = 0;
    s_req_valid = '0; s_req_id = '0; s_req_addr = '0; s_req_data = '0; s_req_rw = '0;
    s_rsp_ready = '1; m_req_ready = 1'b0;
    m_rsp_valid = 1'b0; m_rsp_tag = '0; m_rsp_data = '0; m_rsp_resp = '0; m_rsp_rw = 1'b0;
    test_reset();
    test_simultaneous();
    test_staggered();
    test_inflight_limit();
    test_rsp_routing();
    test_backpressure_badtag();
    test_reset_midburst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
